div_cfg_sequencer: RTL

- Controller that sits between the host wire-in endpoints and the six programmable clock dividers.
- Host values (high/low/wait counts per channel) land in shadow registers.
- A commit pulse applies the selected channels atomically: hold those dividers in reset, load the new counts, then release all of them in the same cycle so their outputs restart phase-aligned.
- Replaces the shared static divider reset with per-channel, glitch-controlled reconfiguration.

---
 rtl/div_cfg_pkg.sv | 44 ++++
 rtl/div_cfg_bank.sv | 37 +++
 rtl/div_cfg_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_cfg_pkg
//  Description : Shared types and reset defaults for the divider configuration
//                sequencer: FSM state encoding, per-channel config record and
//                the power-on count values.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_cfg_pkg;

    // Width of every count field carried in the channel record.
    localparam int CW_DEF = 32;

    // Counts that every shadow and active register returns to on reset.
    localparam logic [CW_DEF-1:0] DEF_HIGH = CW_DEF'(1);
    localparam logic [CW_DEF-1:0] DEF_LOW  = CW_DEF'(1);
    localparam logic [CW_DEF-1:0] DEF_WAIT = CW_DEF'(0);

    // Commit sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // One divider channel's configuration (wait is a keyword, hence wait_cnt).
    typedef struct packed {
        logic [CW_DEF-1:0] high;
        logic [CW_DEF-1:0] low;
        logic [CW_DEF-1:0] wait_cnt;
    } ch_cfg_t;

    // Reset value of a channel record.
    function automatic ch_cfg_t cfg_default();
        ch_cfg_t c;
        c.high     = DEF_HIGH;
        c.low      = DEF_LOW;
        c.wait_cnt = DEF_WAIT;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : div_cfg_bank
//  Description : N_CH-entry shadow register file holding host-written divider
//                counts. Writes to an index with no matching entry are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_cfg_bank
    import div_cfg_pkg::*;
#(
    parameter int N_CH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [2:0]         wr_ch,
    input  ch_cfg_t            wr_data,
    output ch_cfg_t [N_CH-1:0] shadow
);

    ch_cfg_t [N_CH-1:0] r_shadow;

    // Shadow write decode; an out-of-range index matches no entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                r_shadow[i] <= cfg_default();
            end else if (wr_en && (wr_ch == 3'(i))) begin
                r_shadow[i] <= wr_data;
            end
        end
    end

    assign shadow = r_shadow;

endmodule
`default_nettype wire

// File: rtl/div_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_cfg_sequencer
//  Description : Applies host-written divider counts atomically. A commit holds
//                the selected dividers in reset, loads their new counts and
//                releases them together so their outputs restart aligned.
//                Optional macro DIV_CFG_VALIDATE_EN rejects channels whose
//                high or low count is zero and flags them on cfg_err.
//                CW must equal div_cfg_pkg::CW_DEF (record field width).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_cfg_sequencer
    import div_cfg_pkg::*;
#(
    parameter int N_CH        = 6,
    parameter int CW          = CW_DEF,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [2:0]         cfg_ch,
    input  logic [CW-1:0]      cfg_high,
    input  logic [CW-1:0]      cfg_low,
    input  logic [CW-1:0]      cfg_wait,
    input  logic               cfg_commit,
    input  logic [N_CH-1:0]    cfg_mask,
    output logic [N_CH*CW-1:0] high_count_o,
    output logic [N_CH*CW-1:0] low_count_o,
    output logic [N_CH*CW-1:0] wait_count_o,
    output logic [N_CH-1:0]    div_rst_o,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [7:0] C_HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_hold_cnt;
    logic [7:0]         w_hold_cnt_nxt;
    logic               w_accept;
    logic               w_empty_commit;
    logic               w_load;
    logic               w_release;

    logic [N_CH-1:0]    r_mask;
    logic [N_CH-1:0]    r_load_ok;
    logic [N_CH-1:0]    r_div_rst;
    logic               r_done;
    logic [N_CH-1:0]    w_valid;
    ch_cfg_t            r_active [N_CH];
    ch_cfg_t [N_CH-1:0] w_shadow;
    ch_cfg_t            w_wr_data;
    logic               w_wr_en;

    // Host writes only land while no commit is in flight.
    assign w_wr_en            = cfg_wr && (r_state == IDLE);
    assign w_wr_data.high     = cfg_high;
    assign w_wr_data.low      = cfg_low;
    assign w_wr_data.wait_cnt = cfg_wait;

    div_cfg_bank #(
        .N_CH (N_CH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_ch   (cfg_ch),
        .wr_data (w_wr_data),
        .shadow  (w_shadow)
    );

    // FSM state and hold-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_accept       = 1'b0;
        w_empty_commit = 1'b0;
        w_load         = 1'b0;
        w_release      = 1'b0;
        busy           = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (cfg_commit) begin
                    if (cfg_mask != '0) begin
                        w_accept       = 1'b1;
                        w_state_nxt    = HOLD;
                        w_hold_cnt_nxt = C_HOLD_INIT;
                    end else begin
                        w_empty_commit = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 8'd1;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                w_release   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef DIV_CFG_VALIDATE_EN
    // A channel with a zero high or low phase cannot run, so it is refused.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_valid[i] = (w_shadow[i].high != '0) && (w_shadow[i].low != '0);
        end
    end

    logic r_err;

    // Error flag is recomputed by each load and otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= |(r_mask & ~w_valid);
        end
    end

    assign cfg_err = r_err;
`else
    assign w_valid = '1;
    assign cfg_err = 1'b0;
`endif

    // Commit datapath: mask capture, active-count load and divider reset control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask    <= '0;
            r_load_ok <= '0;
            r_div_rst <= '1;
            r_done    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_active[i] <= cfg_default();
            end
        end else begin
            r_done <= w_release || w_empty_commit;
            if (w_accept) begin
                r_mask    <= cfg_mask;
                r_div_rst <= r_div_rst | cfg_mask;
            end
            if (w_load) begin
                r_load_ok <= r_mask & w_valid;
                for (int i = 0; i < N_CH; i++) begin
                    if (r_mask[i] && w_valid[i]) begin
                        r_active[i] <= w_shadow[i];
                    end
                end
            end
            if (w_release) begin
                r_div_rst <= r_div_rst & ~r_load_ok;
            end
        end
    end

    // Flatten active records onto the per-field output buses.
    for (genvar i = 0; i < N_CH; i++) begin : g_ports
        assign high_count_o[i*CW +: CW] = r_active[i].high;
        assign low_count_o[i*CW +: CW]  = r_active[i].low;
        assign wait_count_o[i*CW +: CW] = r_active[i].wait_cnt;
    end

    assign div_rst_o = r_div_rst;
    assign done      = r_done;

endmodule
`default_nettype wire
